// File: rtl/edge_detect_array.sv
// -----------------------------------------------------------------------------
// edge_detect_array
//
// Multi-channel synchroniser, optional debouncer and edge detector for raw
// board inputs (buttons, switches, external strobes). Each channel yields a
// filtered level, a one-cycle event pulse for the selected edge type and a
// sticky pending flag. An OR of all pending flags drives the interrupt line.
//
// Configuration macro:
//   EDGE_DEBOUNCE_EN  defined   -> per-channel debounce counters; level
//                                  changes only after DB_CYCLES consecutive
//                                  cycles of a differing synchronised input.
//                     undefined -> no counters; level follows the
//                                  synchronised input every cycle and
//                                  DB_CYCLES is ignored.
//
// Parameters:
//   CH           number of independent channels (>= 1)
//   SYNC_STAGES  synchroniser depth (>= 2)
//   DB_CYCLES    stable cycles required before level changes (>= 1)
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   sig_in   in   CH  raw asynchronous inputs
//   mode     in   2   edge select: 00 none, 01 rise, 10 fall, 11 both
//   clr      in   CH  clear of pending, one bit per channel
//   level    out  CH  synchronised, filtered level
//   pulse    out  CH  one-cycle event strobe
//   pending  out  CH  sticky event flags
//   irq      out  1   OR of pending
// -----------------------------------------------------------------------------
module edge_detect_array #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] sig_in,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] clr,
    output logic [CH-1:0] level,
    output logic [CH-1:0] pulse,
    output logic [CH-1:0] pending,
    output logic          irq
);

    if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_params
        $error("edge_detect_array: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0][CH-1:0] r_sync;
    logic [CH-1:0]                  r_level;
    logic [CH-1:0]                  r_pulse;
    logic [CH-1:0]                  r_pending;

    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_update;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the pins, the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int            CW     = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

    logic [CH-1:0][CW-1:0] r_cnt;

    // The counter runs only while the synchronised input disagrees with the
    // filtered level; any agreement discards the partial count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (w_sync[i] == r_level[i] || r_cnt[i] == C_LAST) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_update = '0;
        for (int i = 0; i < CH; i++) begin
            w_update[i] = (w_sync[i] != r_level[i]) && (r_cnt[i] == C_LAST);
        end
    end
`else
    assign w_update = w_sync ^ r_level;
`endif

    assign w_rise = w_update &  w_sync;
    assign w_fall = w_update & ~w_sync;

    // Level and pulse update on the same edge. A pulse present at an edge
    // sets pending even if clr is also asserted on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_pulse   <= '0;
            r_pending <= '0;
        end else begin
            r_level   <= (r_level & ~w_update) | (w_sync & w_update);
            r_pulse   <= (w_rise & {CH{mode[0]}}) | (w_fall & {CH{mode[1]}});
            r_pending <= r_pulse | (r_pending & ~clr);
        end
    end

    assign level   = r_level;
    assign pulse   = r_pulse;
    assign pending = r_pending;
    assign irq     = |r_pending;

endmodule

// File: tb/tb_edge_detect_array.sv
module tb_edge_detect_array;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int DB = 4;
`ifdef EDGE_DEBOUNCE_EN
    localparam int DBM = DB;
`else
    localparam int DBM = 1;
`endif
    localparam int LAT = SS + DBM;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] sig_in;
    logic [1:0]    mode;
    logic [CH-1:0] clr;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] pending;
    logic          irq;
    bit            clk_run;

    edge_detect_array #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .DB_CYCLES   (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_in  (sig_in),
        .mode    (mode),
        .clr     (clr),
        .level   (level),
        .pulse   (pulse),
        .pending (pending),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pls;
        logic [CH-1:0] pnd;
        logic          irq;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [CH-1:0] m_pipe[$];
    int            m_run[CH];
    logic [CH-1:0] m_lvl, m_pls, m_pnd;

    int            checks = 0;
    int            errors = 0;
    int            ncyc;
    int            pcnt[CH];
    int            first_p[CH];
    logic [CH-1:0] lvl_seen;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: input delayed by the synchroniser depth; a channel's
    // level flips once the delayed input has disagreed with it for DBM
    // consecutive edges. Events follow the mode in force on that edge.
    task automatic model_reset();
        m_pipe = {};
        for (int s = 0; s < SS; s++) m_pipe.push_back('0);
        for (int i = 0; i < CH; i++) m_run[i] = 0;
        m_lvl = '0;
        m_pls = '0;
        m_pnd = '0;
    endtask

    task automatic model_edge();
        logic [CH-1:0] s, nl, np;
        s = m_pipe.pop_front();
        m_pipe.push_back(sig_in);
        nl = m_lvl;
        np = '0;
        for (int i = 0; i < CH; i++) begin
            if (s[i] != m_lvl[i]) m_run[i]++;
            else                  m_run[i] = 0;
            if (m_run[i] == DBM) begin
                m_run[i] = 0;
                nl[i]    = s[i];
                np[i]    = s[i] ? mode[0] : mode[1];
            end
        end
        m_pnd = m_pls | (m_pnd & ~clr);
        m_pls = np;
        m_lvl = nl;
        exp_q.push_back('{lvl: m_lvl, pls: m_pls, pnd: m_pnd, irq: |m_pnd});
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("level",   int'(level),   int'(mon_e.lvl));
            chk("pulse",   int'(pulse),   int'(mon_e.pls));
            chk("pending", int'(pending), int'(mon_e.pnd));
            chk("irq",     int'(irq),     int'(mon_e.irq));
        end
    end

    task automatic clear_obs();
        ncyc     = 0;
        lvl_seen = '0;
        for (int i = 0; i < CH; i++) begin
            pcnt[i]    = 0;
            first_p[i] = -1;
        end
    endtask

    // Called at a falling edge: drive inputs, predict the next rising edge,
    // then advance to the following falling edge and note what the DUT shows.
    task automatic step(input logic [CH-1:0] s, input logic [1:0] m, input logic [CH-1:0] c);
        sig_in = s;
        mode   = m;
        clr    = c;
        model_edge();
        @(negedge clk);
        ncyc++;
        for (int i = 0; i < CH; i++) begin
            if (pulse[i]) begin
                pcnt[i]++;
                if (first_p[i] < 0) first_p[i] = ncyc;
            end
        end
        lvl_seen = lvl_seen | level;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CH-1:0] rs;
        logic [1:0]    rm;
        logic [CH-1:0] rc;
        int            hold[CH];

        // Reset with no clock running
        clk_run = 1'b0;
        rst_n   = 1'b1;
        sig_in  = 4'hF;
        mode    = 2'b01;
        clr     = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_level",   int'(level),   0);
        chk("rst_pulse",   int'(pulse),   0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_irq",     int'(irq),     0);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_obs();
        for (int n = 1; n <= LAT + 1; n++) begin
            step(4'hF, 2'b01, '0);
            if (n == LAT) begin
                chk("rel_pulse_on",  int'(pulse),   4'hF);
                chk("rel_pend_late", int'(pending), 0);
            end
            if (n == LAT + 1) begin
                chk("rel_pulse_off", int'(pulse),   0);
                chk("rel_pending",   int'(pending), 4'hF);
                chk("rel_irq",       int'(irq),     1);
            end
        end

        // Bring all channels low and clear everything
        repeat (12) step('0, 2'b11, 4'hF);
        step('0, 2'b11, '0);

`ifdef EDGE_DEBOUNCE_EN
        // Glitch shorter than the debounce window
        clear_obs();
        repeat (3) step(4'h1, 2'b11, '0);
        repeat (8) step(4'h0, 2'b11, '0);
        chk("glitch_pulses", pcnt[0], 0);
        chk("glitch_level",  int'(lvl_seen[0]), 0);
`endif
        clear_obs();
        repeat (4)  step(4'h1, 2'b11, '0);
        repeat (10) step(4'h0, 2'b11, '0);
        chk("accept_edge", first_p[0], LAT);

        // Falling-only mode
        clear_obs();
        repeat (10) step(4'h2, 2'b10, '0);
        repeat (10) step(4'h0, 2'b10, '0);
        chk("mode10_count", pcnt[1], 1);
        chk("mode10_edge",  first_p[1], 10 + LAT);

        // No-event mode: level still tracks
        clear_obs();
        repeat (10) step(4'h2, 2'b00, '0);
        repeat (10) step(4'h0, 2'b00, '0);
        chk("mode00_count", pcnt[1], 0);
        chk("mode00_level", int'(lvl_seen[1]), 1);
        repeat (2) step('0, 2'b00, 4'hF);
        chk("quiet_irq", int'(irq), 0);

        // Pending set, clear alone, clear colliding with a pulse
        for (int n = 1; n <= LAT + 1; n++) step(4'h4, 2'b01, '0);
        chk("pend2_set", int'(pending[2]), 1);
        chk("pend2_irq", int'(irq), 1);
        step(4'h4, 2'b01, 4'h4);
        chk("pend2_clr",     int'(pending[2]), 0);
        chk("pend2_irq_clr", int'(irq), 0);
        for (int n = 1; n <= LAT + 1; n++)
            step(4'h0, 2'b11, (n == LAT + 1) ? 4'h4 : 4'h0);
        chk("pend2_set_wins", int'(pending[2]), 1);
        step(4'h0, 2'b11, 4'h4);
        chk("pend2_clr2", int'(pending[2]), 0);

        // Asynchronous reset in the middle of a debounce count on ch3
        repeat (4) step(4'h8, 2'b01, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_level",   int'(level),   0);
        chk("mid_pending", int'(pending), 0);
        chk("mid_pulse",   int'(pulse),   0);
        sig_in = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        repeat (10) step('0, 2'b01, '0);
        chk("mid_no_pulse", pcnt[3], 0);

        // Randomised traffic
        rs = '0;
        rm = 2'b11;
        for (int i = 0; i < CH; i++) hold[i] = $urandom_range(1, 2 * DBM + 2);
        repeat (600) begin
            for (int i = 0; i < CH; i++) begin
                if (hold[i] == 0) begin
                    rs[i]   = ~rs[i];
                    hold[i] = $urandom_range(1, 2 * DBM + 2);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 15) == 0) rm = 2'($urandom);
            rc = ($urandom_range(0, 5) == 0) ? CH'($urandom) : '0;
            step(rs, rm, rc);
        end
        repeat (3) step(rs, rm, '0);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
